// File: rtl/logic_wb_buffer_pkg.sv
// Shared pipeline definitions for the logic-unit writeback path.
package logic_wb_buffer_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    LOP_NOT = 2'b00,
    LOP_AND = 2'b01,
    LOP_OR  = 2'b10,
    LOP_XOR = 2'b11
  } logic_op_e;

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH-entry FIFO of writeback entries; exposes raw storage and the
// read pointer so the owner can scan live entries in age order.
module wb_fifo
  import logic_wb_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  wb_entry_t        i_wdata,
  output wb_entry_t        o_head,
  output wb_entry_t        o_entries [DEPTH],
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0] o_count
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  wb_entry_t        r_mem [DEPTH];
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_entries = r_mem;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_count   = r_count;

  ap_no_overflow:  assert property (@(posedge clk) disable iff (rst) i_push |-> !w_full);
  ap_no_underflow: assert property (@(posedge clk) disable iff (rst) i_pop  |-> !w_empty);

endmodule

// File: rtl/logic_wb_buffer.sv
// Logic-unit result buffer: queues results for the register-file write port
// and forwards the youngest buffered value for a queried source tag.
module logic_wb_buffer
  import logic_wb_buffer_pkg::*;
#(
  parameter  int unsigned DATA_W = logic_wb_buffer_pkg::DATA_W,
  parameter  int unsigned REG_AW = logic_wb_buffer_pkg::REG_AW,
  parameter  int unsigned DEPTH  = 2,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] fwd_rs,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count
);

  logic             w_push;
  logic             w_pop;
  wb_entry_t        w_wdata;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [PTR_W-1:0] w_rd_ptr;
  logic [CNT_W-1:0] w_count;

  assign w_push  = ex_valid & ex_ready & ex_we;
  assign w_pop   = wb_valid & wb_ready;
  assign w_wdata = '{rd: ex_rd, data: ex_result};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (flush),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wdata  (w_wdata),
    .o_head   (w_head),
    .o_entries(w_entries),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count)
  );

  assign ex_ready = (w_count != CNT_W'(DEPTH));
  assign wb_valid = (w_count != '0);
  assign count    = w_count;

  // Storage is not reset, so the head is masked to read zero while empty.
  assign wb_rd   = wb_valid ? w_head.rd   : '0;
  assign wb_data = wb_valid ? w_head.data : '0;

  // Walk live entries oldest to youngest; the last match wins.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    v_idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      v_idx = w_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < w_count) && (w_entries[v_idx].rd == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = w_entries[v_idx].data;
      end
    end
  end

endmodule

// File: tb/tb_logic_wb_buffer.sv
// Scoreboard bench for logic_wb_buffer: a queue-based model tracks buffered
// results; a negedge monitor compares every DUT output against it.
module tb_logic_wb_buffer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_we;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic [1:0]  count;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic        prev_stall = 1'b0;
  logic [4:0]  prev_rd;
  logic [63:0] prev_data;

  logic_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_we    (ex_we),
    .ex_rd    (ex_rd),
    .ex_result(ex_result),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .fwd_rs   (fwd_rs),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus; returns #1 after the capturing edge.
  task automatic cyc(input logic v, input logic we, input logic [4:0] rd,
                     input logic [63:0] d, input logic wr, input logic fl,
                     input logic [4:0] fs);
    ex_valid  = v;
    ex_we     = we;
    ex_rd     = rd;
    ex_result = d;
    wb_ready  = wr;
    flush     = fl;
    fwd_rs    = fs;
    @(posedge clk);
    #1;
  endtask

  // Monitor and reference model: check outputs mid-cycle, then apply the edge's effect.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        prev_stall = 1'b0;
      end
      begin
        logic        e_valid;
        logic        e_hit;
        logic [63:0] e_fdata;
        e_valid = (mq.size() != 0);
        e_hit   = 1'b0;
        e_fdata = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (mq[i].rd == fwd_rs) begin
            e_hit   = 1'b1;
            e_fdata = mq[i].data;
            break;
          end
        end
        chk("wb_valid", 64'(wb_valid), 64'(e_valid));
        chk("count",    64'(count),    64'(mq.size()));
        chk("ex_ready", 64'(ex_ready), 64'(mq.size() != DEPTH));
        chk("wb_rd",    64'(wb_rd),    e_valid ? 64'(mq[0].rd) : 64'd0);
        chk("wb_data",  wb_data,       e_valid ? mq[0].data : 64'd0);
        chk("fwd_hit",  64'(fwd_hit),  64'(e_hit));
        chk("fwd_data", fwd_data,      e_fdata);
        if (prev_stall && !rst) begin
          chk("head_stable_rd",   64'(wb_rd), 64'(prev_rd));
          chk("head_stable_data", wb_data,    prev_data);
        end
        if (!rst) begin
          logic do_pop;
          logic do_push;
          do_pop     = e_valid && wb_ready;
          do_push    = ex_valid && ex_we && (mq.size() < DEPTH);
          prev_stall = e_valid && !wb_ready && !flush;
          prev_rd    = wb_rd;
          prev_data  = wb_data;
          if (flush) mq.delete();
          else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{rd: ex_rd, data: ex_result});
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_rd = '0;
    ex_result = '0; wb_ready = 1'b0; fwd_rs = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ex_ready", 64'(ex_ready), 64'd1);
    chk("reset_count",    64'(count),    64'd0);

    // Latency and ordering
    cyc(1, 1, 5'd3, 64'hFFFF_0000_FFFF_0000, 1, 0, 0);
    chk("lat_rd3", 64'(wb_rd), 64'd3);
    cyc(1, 1, 5'd4, 64'h1, 1, 0, 0);
    chk("lat_rd4", 64'(wb_rd), 64'd4);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lat_empty", 64'(wb_valid), 64'd0);

    // Full and backpressure
    cyc(1, 1, 5'd10, 64'hAAAA_5555_0000_1111, 0, 0, 0);
    cyc(1, 1, 5'd11, 64'h1234_5678_9ABC_DEF0, 0, 0, 0);
    chk("full_count", 64'(count),    64'd2);
    chk("full_ready", 64'(ex_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 5'd12, 64'hDEAD, 0, 0, 0);
      chk("hold_rd",   64'(wb_rd), 64'd10);
      chk("hold_data", wb_data,    64'hAAAA_5555_0000_1111);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("pop_ready", 64'(ex_ready), 64'd1);
    chk("pop_count", 64'(count),    64'd1);

    // Push+pop at count=1
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 5'(20 + i), 64'(100 + i), 1, 0, 0);
      chk("pp_count", 64'(count), 64'd1);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);

    // Forwarding
    cyc(1, 1, 5'd7, 64'hA, 0, 0, 0);
    cyc(1, 1, 5'd7, 64'hB, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 5'd7);
    chk("fwd7_hit",  64'(fwd_hit), 64'd1);
    chk("fwd7_data", fwd_data,     64'hB);
    cyc(0, 0, 0, 0, 0, 0, 5'd8);
    chk("fwd8_hit",  64'(fwd_hit), 64'd0);
    chk("fwd8_data", fwd_data,     64'd0);

    // Flush with concurrent push, then a no-write handshake
    cyc(1, 1, 5'd9, 64'h99, 0, 1, 5'd9);
    chk("flush_count", 64'(count),    64'd0);
    chk("flush_valid", 64'(wb_valid), 64'd0);
    cyc(1, 0, 5'd9, 64'h98, 0, 0, 5'd9);
    chk("nowe_count", 64'(count), 64'd0);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // Reset mid-stream with two entries held
    cyc(1, 1, 5'd5, 64'h55, 0, 0, 5'd5);
    cyc(1, 1, 5'd6, 64'h66, 0, 0, 5'd5);
    rst = 1'b1;
    #1;
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_fwd_hit",  64'(fwd_hit),  64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
          5'($urandom_range(0, 7)), {$urandom, $urandom},
          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
          5'($urandom_range(0, 7)));
    end

    cyc(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
